// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register sentinel
// and the ALU function select.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufun_e;
endpackage

// File: rtl/alu.sv
// W-bit wrap-around ALU; SUB is b - a so that subq rA,rB yields valB - valA.
module alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   control,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         overflow
);
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (alufun_e'(control))
      ALU_ADD: begin
        out      = b + a;
        overflow = (a[W-1] == b[W-1]) && (out[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        out      = b - a;
        overflow = (a[W-1] != b[W-1]) && (out[W-1] != b[W-1]);
      end
      ALU_AND: out = a & b;
      ALU_XOR: out = a ^ b;
      default: out = '0;
    endcase
  end
endmodule

// File: rtl/cond_eval.sv
// Jump/cmov condition from ifun and the current condition codes.
module cond_eval (
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);
  logic lt;
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      4'd0: cnd = 1'b1;
      4'd1: cnd = lt | zf;
      4'd2: cnd = lt;
      4'd3: cnd = zf;
      4'd4: cnd = ~zf;
      4'd5: cnd = ~lt;
      4'd6: cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, cmov squash
// and the M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);
  logic [W-1:0] alu_a, alu_b;
  alufun_e      alufun;
  logic         alu_ovf;
  logic         set_cc;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = {{(W-4){1'b1}}, 4'h8};
      I_RET, I_POPQ:                alu_a = W'(8);
      default:                      alu_a = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
      default: alu_b = '0;
    endcase
    alufun = (E_icode == I_OPQ) ? alufun_e'(E_ifun[1:0]) : ALU_ADD;
  end

  alu #(.W(W)) u_alu (
    .control  (alufun),
    .a        (alu_a),
    .b        (alu_b),
    .out      (e_valE),
    .overflow (alu_ovf)
  );

  // Condition codes
  logic cc_zf_q, cc_sf_q, cc_of_q;
  logic cc_zf_d, cc_sf_d, cc_of_d;

  assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK) && !rst;

  always_comb begin
    cc_zf_d = cc_zf_q;
    cc_sf_d = cc_sf_q;
    cc_of_d = cc_of_q;
    if (set_cc) begin
      cc_zf_d = (e_valE == '0);
      cc_sf_d = e_valE[W-1];
      cc_of_d = ((alufun == ALU_ADD) || (alufun == ALU_SUB)) ? alu_ovf : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else begin
      cc_zf_q <= cc_zf_d;
      cc_sf_q <= cc_sf_d;
      cc_of_q <= cc_of_d;
    end
  end

  // Conditions are evaluated against the CC before this cycle's update lands.
  cond_eval u_cond (
    .ifun (E_ifun),
    .zf   (cc_zf_q),
    .sf   (cc_sf_q),
    .of   (cc_of_q),
    .cnd  (e_Cnd)
  );

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  // M pipeline register; reset and bubble both load the NOP bubble.
  logic [2:0]   m_stat_q;
  logic [3:0]   m_icode_q, m_dstE_q, m_dstM_q;
  logic         m_cnd_q;
  logic [W-1:0] m_valE_q, m_valA_q;

  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_valE_q  <= '0;
      m_valA_q  <= '0;
      m_dstE_q  <= RNONE;
      m_dstM_q  <= RNONE;
    end else begin
      m_stat_q  <= E_stat;
      m_icode_q <= E_icode;
      m_cnd_q   <= e_Cnd;
      m_valE_q  <= e_valE;
      m_valA_q  <= E_valA;
      m_dstE_q  <= e_dstE;
      m_dstM_q  <= E_dstM;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_Cnd   = m_cnd_q;
  assign M_valE  = m_valE_q;
  assign M_valA  = m_valA_q;
  assign M_dstE  = m_dstE_q;
  assign M_dstM  = m_dstM_q;
  assign cc_zf   = cc_zf_q;
  assign cc_sf   = cc_sf_q;
  assign cc_of   = cc_of_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases pinned to literal values, then
// random traffic checked every cycle against a behavioural model.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd, cc_zf, cc_sf, cc_of;
  logic [2:0]  M_stat;

  always #5 clk = ~clk;

  execute_stage #(.W(64)) dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .M_stat(M_stat),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  int checks = 0;
  int failures = 0;

  // Model state: CC as {ZF,SF,OF} and the M register contents.
  logic [2:0]  mcc;
  logic [2:0]  mM_stat;
  logic [3:0]  mM_icode, mM_dstE, mM_dstM;
  logic        mM_Cnd;
  logic [63:0] mM_valE, mM_valA;
  bit          mvalid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // What the stage must produce for the current E inputs and model CC.
  task automatic model_comb(output logic [63:0] valE, output logic cnd,
                            output logic [3:0] dstE, output logic [2:0] ccn);
    logic [63:0] a, b;
    logic signed [64:0] wide;
    logic of, lt, zf;
    int fun;
    a = 0; b = 0; of = 0;
    case (E_icode)
      4'h2, 4'h6:       a = E_valA;
      4'h3, 4'h4, 4'h5: a = E_valC;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 0;
    endcase
    if (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = E_valB;
    fun = (E_icode == 4'h6) ? int'(E_ifun) % 4 : 0;
    case (fun)
      0: begin wide = $signed({b[63], b}) + $signed({a[63], a}); valE = wide[63:0]; of = wide[64] != wide[63]; end
      1: begin wide = $signed({b[63], b}) - $signed({a[63], a}); valE = wide[63:0]; of = wide[64] != wide[63]; end
      2: valE = a & b;
      default: valE = a ^ b;
    endcase
    ccn = {valE == 64'd0, valE[63], of};
    zf = mcc[2];
    lt = mcc[1] ^ mcc[0];
    case (E_ifun)
      4'd0: cnd = 1;
      4'd1: cnd = lt || zf;
      4'd2: cnd = lt;
      4'd3: cnd = zf;
      4'd4: cnd = !zf;
      4'd5: cnd = !lt;
      4'd6: cnd = !lt && !zf;
      default: cnd = 0;
    endcase
    dstE = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
  endtask

  task automatic check_all();
    logic [63:0] v; logic c; logic [3:0] d; logic [2:0] n;
    @(negedge clk);
    if (!mvalid) return;
    model_comb(v, c, d, n);
    chk("e_valE", e_valE, v);
    chk("e_Cnd", 64'(e_Cnd), 64'(c));
    chk("e_dstE", 64'(e_dstE), 64'(d));
    chk("M_stat", 64'(M_stat), 64'(mM_stat));
    chk("M_icode", 64'(M_icode), 64'(mM_icode));
    chk("M_Cnd", 64'(M_Cnd), 64'(mM_Cnd));
    chk("M_valE", M_valE, mM_valE);
    chk("M_valA", M_valA, mM_valA);
    chk("M_dstE", 64'(M_dstE), 64'(mM_dstE));
    chk("M_dstM", 64'(M_dstM), 64'(mM_dstM));
    chk("cc", 64'({cc_zf, cc_sf, cc_of}), 64'(mcc));
  endtask

  task automatic load_bubble();
    mM_stat = 3'd1; mM_icode = 4'h1; mM_Cnd = 0; mM_valE = 0; mM_valA = 0;
    mM_dstE = 4'hF; mM_dstM = 4'hF;
  endtask

  task automatic tick();
    logic [63:0] v; logic c; logic [3:0] d; logic [2:0] n;
    @(posedge clk);
    model_comb(v, c, d, n);
    if (rst) begin
      mcc = 3'b100;
      load_bubble();
      mvalid = 1;
    end else begin
      if (E_icode == 4'h6 && m_stat == 3'd1 && W_stat == 3'd1) mcc = n;
      if (M_bubble) load_bubble();
      else begin
        mM_stat = E_stat; mM_icode = E_icode; mM_Cnd = c; mM_valE = v;
        mM_valA = E_valA; mM_dstE = d; mM_dstM = E_dstM;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; E_stat = 3'd1; E_icode = 4'h1; E_ifun = 0; E_valA = 0; E_valB = 0;
    E_valC = 0; E_dstE = 4'hF; E_dstM = 4'hF; m_stat = 3'd1; W_stat = 3'd1; M_bubble = 0;
  endtask

  task automatic opq(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    idle(); E_icode = 4'h6; E_ifun = f; E_valA = a; E_valB = b; E_dstE = 4'd2;
  endtask

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    idle(); rst = 1;
    tick();
    // Reset state
    idle(); check_all();
    chk("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'h4);
    chk("rst_M_icode", 64'(M_icode), 64'h1);
    chk("rst_M_stat", 64'(M_stat), 64'h1);
    chk("rst_M_dstE", 64'(M_dstE), 64'hF);
    chk("rst_M_dstM", 64'(M_dstM), 64'hF);
    chk("rst_M_valE", M_valE, 64'h0);
    tick();

    // Signed overflow on add
    opq(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); check_all();
    chk("add_ovf_valE", e_valE, 64'h8000_0000_0000_0000);
    tick();
    chk("add_ovf_cc", 64'({cc_zf, cc_sf, cc_of}), 64'h3);

    // sub equal, then je
    opq(4'd1, 64'd5, 64'd5); check_all();
    chk("sub_eq_valE", e_valE, 64'd0);
    tick();
    chk("sub_eq_zf", 64'(cc_zf), 64'd1);
    idle(); E_icode = 4'h7; E_ifun = 4'd3; check_all();
    chk("je_cnd", 64'(e_Cnd), 64'd1);
    tick();
    chk("je_M_Cnd", 64'(M_Cnd), 64'd1);

    // Result 0x8000.. with no overflow: ZF0 SF1 OF0, then cmovge squashed
    opq(4'd0, 64'h8000_0000_0000_0000, 64'd0); check_all(); tick();
    chk("sf_only_cc", 64'({cc_zf, cc_sf, cc_of}), 64'h2);
    idle(); E_icode = 4'h2; E_ifun = 4'd5; E_dstE = 4'd3; check_all();
    chk("cmovge_cnd", 64'(e_Cnd), 64'd0);
    chk("cmovge_dstE", 64'(e_dstE), 64'hF);
    tick();
    chk("cmovge_M_dstE", 64'(M_dstE), 64'hF);

    // Stack pointer adjust
    idle(); E_icode = 4'hA; E_valB = 64'h100; check_all();
    chk("pushq_valE", e_valE, 64'hF8);
    tick();
    idle(); E_icode = 4'hB; E_valB = 64'h100; check_all();
    chk("popq_valE", e_valE, 64'h108);
    tick();
    chk("stack_cc_hold", 64'({cc_zf, cc_sf, cc_of}), 64'h2);

    // Downstream exception freezes CC
    opq(4'd3, 64'd5, 64'd5); m_stat = 3'd3; check_all(); tick();
    chk("exc_cc_hold", 64'({cc_zf, cc_sf, cc_of}), 64'h2);
    chk("exc_M_icode", 64'(M_icode), 64'h6);
    // Bubble still lets CC update
    opq(4'd3, 64'd5, 64'd5); M_bubble = 1; check_all(); tick();
    chk("bub_M_icode", 64'(M_icode), 64'h1);
    chk("bub_M_valE", M_valE, 64'd0);
    chk("bub_M_dstE", 64'(M_dstE), 64'hF);
    chk("bub_cc", 64'({cc_zf, cc_sf, cc_of}), 64'h4);
    // Reset wins over bubble and over a CC-setting OPQ
    opq(4'd3, 64'd1, 64'd2); M_bubble = 1; rst = 1; check_all(); tick();
    chk("rstbub_cc", 64'({cc_zf, cc_sf, cc_of}), 64'h4);
    chk("rstbub_M_icode", 64'(M_icode), 64'h1);
    idle(); check_all(); tick();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 40) == 0);
      E_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      E_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      E_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      E_valA   = rv();
      E_valB   = rv();
      E_valC   = rv();
      E_dstE   = 4'($urandom_range(0, 15));
      E_dstM   = 4'($urandom_range(0, 15));
      m_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      M_bubble = ($urandom_range(0, 7) == 0);
      check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
